// File: rtl/mem_arbiter_ctrl.sv
// Round-robin arbiter between icache and dcache ports onto one RAM port.
// Completion is signalled combinationally when RAM reports ACCESS.
module mem_arbiter_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             iREN,
    input  logic [31:0]      iaddr,
    output logic [31:0]      iload,
    output logic             iwait,
    input  logic             dREN,
    input  logic             dWEN,
    input  logic [31:0]      daddr,
    input  logic [31:0]      dstore,
    output logic [31:0]      dload,
    output logic             dwait,
    output logic             ramREN,
    output logic             ramWEN,
    output logic [31:0]      ramaddr,
    output logic [31:0]      ramstore,
    input  logic [31:0]      ramload,
    input  logic [1:0]       ramstate,
    output logic             bus_err,
    output logic [CNT_W-1:0] icount,
    output logic [CNT_W-1:0] dcount
);

    localparam int WCNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, INSTR} state_t;
    typedef enum logic {G_INSTR, G_DATA} grant_t;

    state_t            state;
    grant_t            last_grant;
    logic [WCNT_W-1:0] wcnt;

    logic d_req;
    logic access;
    logic timeout;

    assign d_req   = dREN | dWEN;
    assign access  = (ramstate == RAM_ACCESS);
    assign timeout = (wcnt == WCNT_LAST);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            last_grant <= G_INSTR;
            wcnt       <= '0;
            bus_err    <= 1'b0;
            icount     <= '0;
            dcount     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    wcnt <= '0;
                    if (d_req && (!iREN || last_grant == G_INSTR))
                        state <= DATA;
                    else if (iREN)
                        state <= INSTR;
                end
                DATA: begin
                    // withdrawal beats completion: no request, no transfer
                    if (!d_req) begin
                        state <= IDLE;
                        wcnt  <= '0;
                    end else if (access) begin
                        state      <= IDLE;
                        wcnt       <= '0;
                        last_grant <= G_DATA;
                        dcount     <= dcount + CNT_W'(1);
                    end else if (timeout) begin
                        state   <= IDLE;
                        wcnt    <= '0;
                        bus_err <= 1'b1;
                    end else begin
                        wcnt <= wcnt + WCNT_W'(1);
                    end
                end
                INSTR: begin
                    if (!iREN) begin
                        state <= IDLE;
                        wcnt  <= '0;
                    end else if (access) begin
                        state      <= IDLE;
                        wcnt       <= '0;
                        last_grant <= G_INSTR;
                        icount     <= icount + CNT_W'(1);
                    end else if (timeout) begin
                        state   <= IDLE;
                        wcnt    <= '0;
                        bus_err <= 1'b1;
                    end else begin
                        wcnt <= wcnt + WCNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        unique case (state)
            DATA: begin
                ramaddr  = daddr;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramstore = dWEN ? dstore : 32'h0;
                if (d_req && access) begin
                    dwait = 1'b0;
                    dload = dWEN ? 32'h0 : ramload;
                end
            end
            INSTR: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (iREN && access) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
            default: ;
        endcase
    end

endmodule
